// File: rtl/mac_result_drain.sv
// Result drain behind the MAC engine: buffers {mode, sum} results in a small FIFO
// and serializes each one as 1/2/4 LSW-first 32-bit beats, depending on the captured mode.
module mac_result_drain #(
    parameter int DEPTH = 2,
    parameter int SUM_W = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             mac_valid,
    output logic             mac_ready,
    input  logic [SUM_W-1:0] mac_sum,
    input  logic [3:0]       mac_mode,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [1:0]       out_beat,
    output logic [CNT_W-1:0] result_count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int NWORDS = SUM_W / 32;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [3:0]       mode_mem [DEPTH];
    logic [SUM_W-1:0] sum_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [1:0]       beat_cnt;

    logic [3:0]       head_mode;
    logic [SUM_W-1:0] head_sum;
    logic [1:0]       last_beat;
    logic [31:0]      head_word;
    logic             is_last;
    logic             push;
    logic             beat_fire;
    logic             pop;

    assign head_mode = mode_mem[rd_ptr];
    assign head_sum  = sum_mem[rd_ptr];

    // Reserved modes fall back to the widest serialization.
    always_comb begin
        case (head_mode)
            4'd1:    last_beat = 2'd1;
            4'd2:    last_beat = 2'd0;
            default: last_beat = 2'd3;
        endcase
    end

    always_comb begin
        head_word = '0;
        for (int k = 0; k < NWORDS && k < 4; k++) begin
            if (beat_cnt == k[1:0]) begin
                head_word = head_sum[32*k +: 32];
            end
        end
    end

    assign mac_ready = (occ != FULL_OCC);
    assign out_valid = (occ != '0);
    assign is_last   = (beat_cnt == last_beat);
    assign push      = mac_valid && mac_ready;
    assign beat_fire = out_valid && out_ready;
    assign pop       = beat_fire && is_last;

    assign out_data = out_valid ? head_word : 32'd0;
    assign out_beat = beat_cnt;
    assign out_last = out_valid && is_last;

    // Storage is not reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (nrst && push) begin
            mode_mem[wr_ptr] <= mac_mode;
            sum_mem[wr_ptr]  <= mac_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            beat_cnt     <= '0;
            result_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (beat_fire) begin
                if (is_last) begin
                    beat_cnt     <= '0;
                    rd_ptr       <= rd_ptr + 1'b1;
                    result_count <= result_count + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: immediate-assertion checks against hand-computed values.
module tb_mac_result_drain;

    logic         clk = 1'b0;
    logic         nrst;
    logic         mac_valid;
    logic         mac_ready;
    logic [127:0] mac_sum;
    logic [3:0]   mac_mode;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [1:0]   out_beat;
    logic [15:0]  result_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w [12];

    mac_result_drain #(.DEPTH(2), .SUM_W(128), .CNT_W(16)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .mac_valid    (mac_valid),
        .mac_ready    (mac_ready),
        .mac_sum      (mac_sum),
        .mac_mode     (mac_mode),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_beat     (out_beat),
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nrst      = 1'b0;
        mac_valid = 1'b0;
        mac_sum   = '0;
        mac_mode  = 4'd0;
        out_ready = 1'b0;
        step();
        step();

        // reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_beat", out_beat, 2'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_count", result_count, 16'd0);
        chk("rst_mac_ready", mac_ready, 1'b1);

        // captures are ignored while in reset
        mac_valid = 1'b1;
        mac_sum   = 128'h1;
        step();
        chk("rst_no_capture", out_valid, 1'b0);
        mac_valid = 1'b0;
        nrst      = 1'b1;
        step();

        // single mode-2 result
        mac_valid = 1'b1;
        mac_mode  = 4'd2;
        mac_sum   = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DEADBEEF;
        out_ready = 1'b1;
        step();
        mac_valid = 1'b0;
        chk("m2_valid", out_valid, 1'b1);
        chk("m2_data", out_data, 32'hDEADBEEF);
        chk("m2_last", out_last, 1'b1);
        chk("m2_beat", out_beat, 2'd0);
        step();
        chk("m2_empty", out_valid, 1'b0);
        chk("m2_count", result_count, 16'd1);

        // mode-0 result, four beats LSW first
        mac_valid = 1'b1;
        mac_mode  = 4'd0;
        mac_sum   = 128'h44444444_33333333_22222222_11111111;
        step();
        mac_valid = 1'b0;
        mac_mode  = 4'd2;
        for (int i = 0; i < 4; i++) begin
            chk("m0_data", out_data, {4{i[7:0] + 8'h11}} & 32'h0 | (32'h11111111 * (i + 1)));
            chk("m0_beat", out_beat, i[1:0]);
            chk("m0_last", out_last, (i == 3));
            step();
        end
        chk("m0_empty", out_valid, 1'b0);
        chk("m0_count", result_count, 16'd2);

        // backpressure on a mode-1 result
        out_ready = 1'b0;
        mac_valid = 1'b1;
        mac_mode  = 4'd1;
        mac_sum   = 128'h0BAD0BAD_0BAD0BAD_87654321_12345678;
        step();
        mac_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", out_data, 32'h12345678);
            chk("bp_hold_beat", out_beat, 2'd0);
            chk("bp_hold_last", out_last, 1'b0);
            step();
        end
        out_ready = 1'b1;
        chk("bp_b0_data", out_data, 32'h12345678);
        step();
        chk("bp_b1_data", out_data, 32'h87654321);
        chk("bp_b1_beat", out_beat, 2'd1);
        chk("bp_b1_last", out_last, 1'b1);
        step();
        chk("bp_empty", out_valid, 1'b0);
        chk("bp_count", result_count, 16'd3);

        // full FIFO with a held third push
        exp_w[0]  = 32'hA0A0A0A0; exp_w[1]  = 32'hA1A1A1A1; exp_w[2]  = 32'hA2A2A2A2; exp_w[3]  = 32'hA3A3A3A3;
        exp_w[4]  = 32'hB0B0B0B0; exp_w[5]  = 32'hB1B1B1B1; exp_w[6]  = 32'hB2B2B2B2; exp_w[7]  = 32'hB3B3B3B3;
        exp_w[8]  = 32'hC0C0C0C0; exp_w[9]  = 32'hC1C1C1C1; exp_w[10] = 32'hC2C2C2C2; exp_w[11] = 32'hC3C3C3C3;
        out_ready = 1'b0;
        mac_valid = 1'b1;
        mac_mode  = 4'd0;
        mac_sum   = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
        step();
        chk("full_ready_1", mac_ready, 1'b1);
        mac_sum = {exp_w[7], exp_w[6], exp_w[5], exp_w[4]};
        step();
        chk("full_ready_2", mac_ready, 1'b0);
        mac_sum = {exp_w[11], exp_w[10], exp_w[9], exp_w[8]};
        step();
        step();
        chk("full_ready_held", mac_ready, 1'b0);
        chk("full_head_held", out_data, exp_w[0]);
        out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            chk("full_word", out_data, exp_w[j]);
            chk("full_last", out_last, (j % 4 == 3));
            if (j == 3) chk("full_ready_before_pop", mac_ready, 1'b0);
            if (j == 4) chk("full_ready_after_pop", mac_ready, 1'b1);
            step();
            if (j == 4) mac_valid = 1'b0;
        end
        chk("full_empty", out_valid, 1'b0);
        chk("full_count", result_count, 16'd6);

        // push and last-beat pop on the same edge
        mac_valid = 1'b1;
        mac_mode  = 4'd2;
        mac_sum   = 128'h55555555;
        step();
        chk("sim_first", out_data, 32'h55555555);
        mac_sum = 128'h66666666;
        step();
        mac_valid = 1'b0;
        chk("sim_valid", out_valid, 1'b1);
        chk("sim_data", out_data, 32'h66666666);
        chk("sim_last", out_last, 1'b1);
        chk("sim_ready", mac_ready, 1'b1);
        step();
        chk("sim_empty", out_valid, 1'b0);
        chk("sim_count", result_count, 16'd8);

        // reset in the middle of a mode-0 drain
        mac_valid = 1'b1;
        mac_mode  = 4'd0;
        mac_sum   = 128'h7D7D7D7D_7C7C7C7C_7B7B7B7B_7A7A7A7A;
        step();
        mac_valid = 1'b0;
        step();
        chk("rmid_beat1", out_data, 32'h7B7B7B7B);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("rmid_valid", out_valid, 1'b0);
        chk("rmid_ready", mac_ready, 1'b1);
        chk("rmid_count", result_count, 16'd0);
        chk("rmid_beat", out_beat, 2'd0);
        step();
        chk("rmid_no_reemit", out_valid, 1'b0);

        // new mode-1 result after reset; mode changes after capture must not matter
        mac_valid = 1'b1;
        mac_mode  = 4'd1;
        mac_sum   = 128'h0_0_9F9F9F9F_9E9E9E9E;
        step();
        mac_valid = 1'b0;
        mac_mode  = 4'd0;
        chk("post_b0_data", out_data, 32'h9E9E9E9E);
        chk("post_b0_beat", out_beat, 2'd0);
        chk("post_b0_last", out_last, 1'b0);
        step();
        chk("post_b1_data", out_data, 32'h9F9F9F9F);
        chk("post_b1_last", out_last, 1'b1);
        step();
        chk("post_count", result_count, 16'd1);

        // reserved mode gives four beats
        mac_valid = 1'b1;
        mac_mode  = 4'd9;
        mac_sum   = 128'h04040404_03030303_02020202_01010101;
        step();
        mac_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rsv_data", out_data, 32'h01010101 * (i + 1));
            chk("rsv_last", out_last, (i == 3));
            step();
        end
        chk("rsv_empty", out_valid, 1'b0);
        chk("rsv_count", result_count, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
